pps_bus_arbiter: RTL and testbench
==================================

Name: pps_bus_arbiter

Overview:
- Two-requester arbiter that shares the single register port of the pps timer wrapper.
- Requester 0 is the picorv32 core. Requester 1 is an autonomous agent, e.g. an event-stamp logger or debug UART bridge.
- Sequences one target transaction at a time and enforces the target's rule that sel must drop for at least one cycle after each ready.
- Sits in the system clock domain, between the bus decode and the pps wrapper.

Parameters:
- PRIORITY_MODE, 0: 0 = round-robin between requesters; 1 = fixed priority, requester 0 always wins.
- TIMEOUT_CYCLES, 1024: BUSY-state cycle limit; used only when PPS_ARB_TIMEOUT_EN is defined.

Ports:
- clk  in  1  system clock; the only clock.
- reset  in  1  asynchronous, active-high reset.
- m0_sel  in  1  requester 0 request; held high until m0_ready.
- m0_addr  in  3  requester 0 word address.
- m0_is_write  in  1  requester 0 write flag.
- m0_wdata  in  32  requester 0 write data.
- m0_ready  out  1  one-cycle completion pulse to requester 0.
- m0_rdata  out  32  requester 0 read data; valid while m0_ready is high.
- m1_sel, m1_addr, m1_is_write, m1_wdata, m1_ready, m1_rdata: same widths and meanings, for requester 1.
- tgt_sel  out  1  target select.
- tgt_addr  out  3  target word address.
- tgt_is_write  out  1  target write flag.
- tgt_wdata  out  32  target write data.
- tgt_ready  in  1  target completion pulse.
- tgt_rdata  in  32  target read data; valid with tgt_ready.
- timeout_err  out  1  one-cycle pulse when a transaction times out.

Behaviour:
- Reset: all outputs are 0, state = IDLE, last_grant = 1 (requester 0 wins the first tie).
- States: IDLE, BUSY, GAP, encoded 2 bits.
- IDLE:
  - When any mN_sel is high: pick a winner.
  - Latch the winner's addr/is_write/wdata into the tgt_* registers, set tgt_sel = 1 and go to BUSY.
  - tgt_sel rises on the cycle after the request is sampled.
- Pick rules:
  - Only one requester high: that requester wins.
  - Both high, PRIORITY_MODE = 0: the requester other than last_grant wins.
  - Both high, PRIORITY_MODE = 1: requester 0 wins.
  - last_grant updates at grant.
- BUSY:
  - tgt_* outputs stay stable.
  - When tgt_ready: clear tgt_sel, register mG_rdata <= tgt_rdata, pulse mG_ready for exactly 1 cycle (the cycle after tgt_ready), go to GAP.
  - For writes, mG_rdata is still loaded but carries no meaning.
- GAP: exactly one cycle with tgt_sel = 0, then IDLE. The requester drops sel during this cycle; its stale sel is not re-sampled.
- Minimum cost per transaction: tgt_sel low for 2 cycles between back-to-back grants.
- Losing requester: holds sel. It is served in the IDLE following the GAP, so there is no starvation in round-robin mode.
- mN_sel dropping during BUSY is illegal. The arbiter still completes the target transaction and the ready pulse goes unobserved.
- tgt_ready while in IDLE or GAP is ignored.
- The ungranted mN_ready stays 0. Each mN_rdata holds its last value until the next completion for that requester.
- Reset asserted mid-transaction: immediate return to reset values. The target is reset by the same reset tree.

Optional Feature:
- Macro: PPS_ARB_TIMEOUT_EN.
- Defined:
  - A counter of width clog2(TIMEOUT_CYCLES+1) clears on entry to BUSY and increments each BUSY cycle.
  - When it reaches TIMEOUT_CYCLES with no tgt_ready: clear tgt_sel, pulse mG_ready with mG_rdata = 32'hDEAD_BEEF, pulse timeout_err, go to GAP.
  - tgt_ready on the same cycle as expiry wins; no error is raised.
- Undefined: no counter; BUSY waits indefinitely; timeout_err is tied to 0.

Decomposition:
- Package pps_arb_pkg holds:
  - state encodings IDLE = 2'd0, BUSY = 2'd1, GAP = 2'd2;
  - TIMEOUT_RDATA = 32'hDEAD_BEEF;
  - PRIO_RR = 0, PRIO_FIXED = 1.
- Sub-module pps_arb_pick (purely combinational):
  - inputs: req[1:0], last_grant, priority mode;
  - outputs: grant_valid, grant_idx.

Test Plan:
- m0 read of addr 3'd0, target returns 32'h1234_5678 after 5 cycles -> tgt_sel high 1 cycle after m0_sel, m0_ready is a 1-cycle pulse with m0_rdata = 32'h1234_5678, m1_ready stays 0.
- m0_sel and m1_sel rise together, both writes, PRIORITY_MODE = 0, out of reset -> m0 served first, then m1; tgt_sel low exactly 2 cycles between them; tgt_wdata matches each requester.
- Both held continuously for 6 transactions -> grants alternate 0,1,0,1,0,1. With PRIORITY_MODE = 1, m0 kept asserted -> m1 never granted until m0 drops.
- m1 read in BUSY, reset pulsed -> all outputs 0 asynchronously; after release, an m1 request is granted normally.
- PPS_ARB_TIMEOUT_EN defined, TIMEOUT_CYCLES = 16, target never readies -> after 16 BUSY cycles m0_ready pulses with 32'hDEAD_BEEF and timeout_err pulses. Repeat with tgt_ready on cycle 16 -> real data returned, no timeout_err.
- tgt_ready injected while in IDLE -> no mN_ready pulse, state unchanged.

Source files
------------

// File: rtl/pps_arb_pkg.sv
// Shared encodings and constants for the pps timer register-port arbiter.
package pps_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    GAP  = 2'd2
  } arb_state_e;

  localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;

  localparam int PRIO_RR    = 0;
  localparam int PRIO_FIXED = 1;

endpackage

// File: rtl/pps_arb_pick.sv
// Combinational winner selection for two requesters (round-robin or fixed priority).
module pps_arb_pick (
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  input  logic       prio_fixed_i,
  output logic       grant_valid_o,
  output logic       grant_idx_o
);

  always_comb begin
    grant_valid_o = |req_i;
    grant_idx_o   = 1'b0;
    if (req_i == 2'b10) begin
      grant_idx_o = 1'b1;
    end else if (req_i == 2'b11) begin
      // On a tie, round-robin hands the port to whoever was not served last.
      grant_idx_o = prio_fixed_i ? 1'b0 : ~last_grant_i;
    end
  end

endmodule

// File: rtl/pps_bus_arbiter.sv
// Two-requester arbiter for the pps wrapper register port. Optional BUSY timeout: PPS_ARB_TIMEOUT_EN.
// Handshake: mN_sel is held high until a one-cycle mN_ready; tgt_sel stays high until tgt_ready, then drops for >= 1 cycle.
module pps_bus_arbiter
  import pps_arb_pkg::*;
#(
  parameter int PRIORITY_MODE  = PRIO_RR,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_sel,
  input  logic [2:0]  m0_addr,
  input  logic        m0_is_write,
  input  logic [31:0] m0_wdata,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,
  input  logic        m1_sel,
  input  logic [2:0]  m1_addr,
  input  logic        m1_is_write,
  input  logic [31:0] m1_wdata,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,
  output logic        tgt_sel,
  output logic [2:0]  tgt_addr,
  output logic        tgt_is_write,
  output logic [31:0] tgt_wdata,
  input  logic        tgt_ready,
  input  logic [31:0] tgt_rdata,
  output logic        timeout_err,
  output logic [1:0]  dbg_state
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  arb_state_e  state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic        gnt_q, gnt_d;
  logic        tgt_sel_q, tgt_sel_d;
  logic [2:0]  tgt_addr_q, tgt_addr_d;
  logic        tgt_is_write_q, tgt_is_write_d;
  logic [31:0] tgt_wdata_q, tgt_wdata_d;
  logic        m0_ready_q, m0_ready_d, m1_ready_q, m1_ready_d;
  logic [31:0] m0_rdata_q, m0_rdata_d, m1_rdata_q, m1_rdata_d;
  logic        timeout_err_q, timeout_err_d;
  logic [31:0] done_rdata;
  logic        grant_valid, grant_idx;
  logic        expire;

  pps_arb_pick u_pick (
    .req_i        ({m1_sel, m0_sel}),
    .last_grant_i (last_grant_q),
    .prio_fixed_i (PRIORITY_MODE == PRIO_FIXED),
    .grant_valid_o(grant_valid),
    .grant_idx_o  (grant_idx)
  );

`ifdef PPS_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;

  // cnt_q holds the number of BUSY cycles already completed, so expiry fires on BUSY cycle TIMEOUT_CYCLES.
  assign expire = (state_q == BUSY) && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == IDLE) cnt_d = '0;
    else if (state_q == BUSY) cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
`else
  assign expire = 1'b0;
`endif

  always_comb begin
    state_d        = state_q;
    last_grant_d   = last_grant_q;
    gnt_d          = gnt_q;
    tgt_sel_d      = tgt_sel_q;
    tgt_addr_d     = tgt_addr_q;
    tgt_is_write_d = tgt_is_write_q;
    tgt_wdata_d    = tgt_wdata_q;
    m0_ready_d     = 1'b0;
    m1_ready_d     = 1'b0;
    m0_rdata_d     = m0_rdata_q;
    m1_rdata_d     = m1_rdata_q;
    timeout_err_d  = 1'b0;
    done_rdata     = tgt_ready ? tgt_rdata : TIMEOUT_RDATA;
    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          state_d        = BUSY;
          gnt_d          = grant_idx;
          last_grant_d   = grant_idx;
          tgt_sel_d      = 1'b1;
          tgt_addr_d     = grant_idx ? m1_addr : m0_addr;
          tgt_is_write_d = grant_idx ? m1_is_write : m0_is_write;
          tgt_wdata_d    = grant_idx ? m1_wdata : m0_wdata;
        end
      end
      BUSY: begin
        if (tgt_ready || expire) begin
          state_d       = GAP;
          tgt_sel_d     = 1'b0;
          timeout_err_d = ~tgt_ready;
          if (gnt_q) begin
            m1_ready_d = 1'b1;
            m1_rdata_d = done_rdata;
          end else begin
            m0_ready_d = 1'b1;
            m0_rdata_d = done_rdata;
          end
        end
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      last_grant_q   <= 1'b1;
      gnt_q          <= 1'b0;
      tgt_sel_q      <= 1'b0;
      tgt_addr_q     <= '0;
      tgt_is_write_q <= 1'b0;
      tgt_wdata_q    <= '0;
      m0_ready_q     <= 1'b0;
      m1_ready_q     <= 1'b0;
      m0_rdata_q     <= '0;
      m1_rdata_q     <= '0;
      timeout_err_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      last_grant_q   <= last_grant_d;
      gnt_q          <= gnt_d;
      tgt_sel_q      <= tgt_sel_d;
      tgt_addr_q     <= tgt_addr_d;
      tgt_is_write_q <= tgt_is_write_d;
      tgt_wdata_q    <= tgt_wdata_d;
      m0_ready_q     <= m0_ready_d;
      m1_ready_q     <= m1_ready_d;
      m0_rdata_q     <= m0_rdata_d;
      m1_rdata_q     <= m1_rdata_d;
      timeout_err_q  <= timeout_err_d;
    end
  end

  assign tgt_sel      = tgt_sel_q;
  assign tgt_addr     = tgt_addr_q;
  assign tgt_is_write = tgt_is_write_q;
  assign tgt_wdata    = tgt_wdata_q;
  assign m0_ready     = m0_ready_q;
  assign m1_ready     = m1_ready_q;
  assign m0_rdata     = m0_rdata_q;
  assign m1_rdata     = m1_rdata_q;
  assign timeout_err  = timeout_err_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_pps_bus_arbiter.sv
// Directed bench for pps_bus_arbiter: instance 0 round-robin, instance 1 fixed priority (TIMEOUT_CYCLES = 16).
module tb_pps_bus_arbiter;
  import pps_arb_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        m0_sel [2];
  logic [2:0]  m0_addr [2];
  logic        m0_is_write [2];
  logic [31:0] m0_wdata [2];
  logic        m1_sel [2];
  logic [2:0]  m1_addr [2];
  logic        m1_is_write [2];
  logic [31:0] m1_wdata [2];
  logic        tgt_ready [2];
  logic [31:0] tgt_rdata [2];
  logic        m0_ready_w [2];
  logic [31:0] m0_rdata_w [2];
  logic        m1_ready_w [2];
  logic [31:0] m1_rdata_w [2];
  logic        tgt_sel_w [2];
  logic [2:0]  tgt_addr_w [2];
  logic        tgt_is_write_w [2];
  logic [31:0] tgt_wdata_w [2];
  logic        timeout_err_w [2];
  logic [1:0]  dbg_state_w [2];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    pps_bus_arbiter #(.PRIORITY_MODE(g), .TIMEOUT_CYCLES(16)) u_dut (
      .clk         (clk),
      .reset       (reset),
      .m0_sel      (m0_sel[g]),
      .m0_addr     (m0_addr[g]),
      .m0_is_write (m0_is_write[g]),
      .m0_wdata    (m0_wdata[g]),
      .m0_ready    (m0_ready_w[g]),
      .m0_rdata    (m0_rdata_w[g]),
      .m1_sel      (m1_sel[g]),
      .m1_addr     (m1_addr[g]),
      .m1_is_write (m1_is_write[g]),
      .m1_wdata    (m1_wdata[g]),
      .m1_ready    (m1_ready_w[g]),
      .m1_rdata    (m1_rdata_w[g]),
      .tgt_sel     (tgt_sel_w[g]),
      .tgt_addr    (tgt_addr_w[g]),
      .tgt_is_write(tgt_is_write_w[g]),
      .tgt_wdata   (tgt_wdata_w[g]),
      .tgt_ready   (tgt_ready[g]),
      .tgt_rdata   (tgt_rdata[g]),
      .timeout_err (timeout_err_w[g]),
      .dbg_state   (dbg_state_w[g])
    );
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    for (int k = 0; k < 2; k++) begin
      m0_sel[k] = 1'b0; m0_addr[k] = '0; m0_is_write[k] = 1'b0; m0_wdata[k] = '0;
      m1_sel[k] = 1'b0; m1_addr[k] = '0; m1_is_write[k] = 1'b0; m1_wdata[k] = '0;
      tgt_ready[k] = 1'b0; tgt_rdata[k] = '0;
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    clear_inputs();
    repeat (2) tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic set_req(input int k, input int who, input logic [2:0] addr,
                         input logic wr, input logic [31:0] wdata);
    if (who == 1) begin
      m1_addr[k] = addr; m1_is_write[k] = wr; m1_wdata[k] = wdata; m1_sel[k] = 1'b1;
    end else begin
      m0_addr[k] = addr; m0_is_write[k] = wr; m0_wdata[k] = wdata; m0_sel[k] = 1'b1;
    end
  endtask

  // One target transaction on instance k, expected to be granted to requester `who`.
  task automatic serve(input int k, input int who, input int lat, input logic [31:0] rdata,
                       input bit drop, output int gap);
    int low = 0;
    bit seen = 0;
    logic [35:0] exp_cmd;
    logic [1:0]  exp_rdy;
    logic [31:0] got_rd;
    exp_cmd = (who == 1) ? {m1_addr[k], m1_is_write[k], m1_wdata[k]}
                         : {m0_addr[k], m0_is_write[k], m0_wdata[k]};
    exp_rdy = (who == 1) ? 2'b10 : 2'b01;
    for (int c = 0; c < 20 && !seen; c++) begin
      tick();
      if (tgt_sel_w[k]) seen = 1;
      else low++;
    end
    gap = low + 1;
    n_tests++;
    if (!seen) begin
      n_fail++;
      $display("FAIL grant_wait inst%0d: tgt_sel=0 after 20 cycles, required 1", k);
    end else begin
      n_tests++;
      if ({tgt_addr_w[k], tgt_is_write_w[k], tgt_wdata_w[k]} !== exp_cmd) begin
        n_fail++;
        $display("FAIL tgt_cmd inst%0d: got %h required %h", k,
                 {tgt_addr_w[k], tgt_is_write_w[k], tgt_wdata_w[k]}, exp_cmd);
      end
      n_tests++;
      if (dbg_state_w[k] !== BUSY) begin
        n_fail++;
        $display("FAIL busy_state inst%0d: got %0d required %0d", k, dbg_state_w[k], BUSY);
      end
      for (int c = 1; c < lat; c++) begin
        tick();
        n_tests++;
        if ({tgt_sel_w[k], m1_ready_w[k], m0_ready_w[k], timeout_err_w[k]} !== 4'b1000) begin
          n_fail++;
          $display("FAIL busy_hold inst%0d cyc%0d: got %b required 1000", k, c,
                   {tgt_sel_w[k], m1_ready_w[k], m0_ready_w[k], timeout_err_w[k]});
        end
      end
      tgt_rdata[k] = rdata;
      tgt_ready[k] = 1'b1;
      tick();
      tgt_ready[k] = 1'b0;
      tgt_rdata[k] = $urandom;
      got_rd = (who == 1) ? m1_rdata_w[k] : m0_rdata_w[k];
      n_tests++;
      if ({m1_ready_w[k], m0_ready_w[k]} !== exp_rdy) begin
        n_fail++;
        $display("FAIL ready_pulse inst%0d: got %b required %b", k,
                 {m1_ready_w[k], m0_ready_w[k]}, exp_rdy);
      end
      n_tests++;
      if (got_rd !== rdata) begin
        n_fail++;
        $display("FAIL rdata inst%0d: got %h required %h", k, got_rd, rdata);
      end
      n_tests++;
      if ({tgt_sel_w[k], timeout_err_w[k], dbg_state_w[k]} !== {2'b00, GAP}) begin
        n_fail++;
        $display("FAIL gap_state inst%0d: got %b required %b", k,
                 {tgt_sel_w[k], timeout_err_w[k], dbg_state_w[k]}, {2'b00, GAP});
      end
    end
    if (drop) begin
      if (who == 1) m1_sel[k] = 1'b0;
      else m0_sel[k] = 1'b0;
    end
  endtask

  task automatic check_zero(input string name);
    for (int k = 0; k < 2; k++) begin
      n_tests++;
      if ({tgt_sel_w[k], tgt_addr_w[k], tgt_is_write_w[k], tgt_wdata_w[k], m0_ready_w[k],
           m0_rdata_w[k], m1_ready_w[k], m1_rdata_w[k], timeout_err_w[k], dbg_state_w[k]} !== '0) begin
        n_fail++;
        $display("FAIL %s inst%0d: outputs %h required all zero", name, k,
                 {tgt_sel_w[k], tgt_addr_w[k], tgt_is_write_w[k], tgt_wdata_w[k], m0_ready_w[k],
                  m0_rdata_w[k], m1_ready_w[k], m1_rdata_w[k], timeout_err_w[k], dbg_state_w[k]});
      end
    end
  endtask

  task automatic test_reset();
    apply_reset();
    check_zero("reset_out");
  endtask

  task automatic test_single_read();
    int gap;
    set_req(0, 0, 3'd0, 1'b0, 32'h0);
    serve(0, 0, 5, 32'h1234_5678, 1, gap);
    n_tests++;
    if (gap !== 1) begin
      n_fail++;
      $display("FAIL sel_latency: got %0d required 1", gap);
    end
    tick();
    n_tests++;
    if ({m1_ready_w[0], m0_ready_w[0], tgt_sel_w[0], dbg_state_w[0], m0_rdata_w[0]} !==
        {3'b000, IDLE, 32'h1234_5678}) begin
      n_fail++;
      $display("FAIL single_after: got %h required %h",
               {m1_ready_w[0], m0_ready_w[0], tgt_sel_w[0], dbg_state_w[0], m0_rdata_w[0]},
               {3'b000, IDLE, 32'h1234_5678});
    end
  endtask

  task automatic test_both_writes();
    int gap;
    apply_reset();
    set_req(0, 0, 3'd1, 1'b1, 32'hA0A0_0001);
    set_req(0, 1, 3'd2, 1'b1, 32'hB1B1_0002);
    serve(0, 0, 2, 32'h0000_0011, 1, gap);
    serve(0, 1, 3, 32'h0000_0022, 1, gap);
    n_tests++;
    if (gap !== 2) begin
      n_fail++;
      $display("FAIL write_gap: got %0d required 2", gap);
    end
    n_tests++;
    if (m0_rdata_w[0] !== 32'h0000_0011) begin
      n_fail++;
      $display("FAIL m0_rdata_hold: got %h required %h", m0_rdata_w[0], 32'h0000_0011);
    end
  endtask

  task automatic test_back_to_back();
    int gap;
    apply_reset();
    set_req(0, 0, 3'd3, 1'b0, 32'h0);
    set_req(0, 1, 3'd4, 1'b0, 32'h0);
    for (int i = 0; i < 6; i++) begin
      serve(0, i % 2, 2, 32'hA000_0000 + i, 0, gap);
      if (i > 0) begin
        n_tests++;
        if (gap !== 2) begin
          n_fail++;
          $display("FAIL rr_gap txn%0d: got %0d required 2", i, gap);
        end
      end
    end
    m0_sel[0] = 1'b0;
    m1_sel[0] = 1'b0;
    repeat (2) tick();
    n_tests++;
    if ({tgt_sel_w[0], dbg_state_w[0]} !== {1'b0, IDLE}) begin
      n_fail++;
      $display("FAIL rr_idle: got %b required %b", {tgt_sel_w[0], dbg_state_w[0]}, {1'b0, IDLE});
    end
  endtask

  task automatic test_idle_ready();
    tgt_rdata[0] = 32'hFFFF_FFFF;
    tgt_ready[0] = 1'b1;
    tick();
    tgt_ready[0] = 1'b0;
    tick();
    n_tests++;
    if ({m1_ready_w[0], m0_ready_w[0], tgt_sel_w[0], dbg_state_w[0], m0_rdata_w[0], m1_rdata_w[0]} !==
        {3'b000, IDLE, 32'hA000_0004, 32'hA000_0005}) begin
      n_fail++;
      $display("FAIL idle_ready: got %h required %h",
               {m1_ready_w[0], m0_ready_w[0], tgt_sel_w[0], dbg_state_w[0], m0_rdata_w[0], m1_rdata_w[0]},
               {3'b000, IDLE, 32'hA000_0004, 32'hA000_0005});
    end
  endtask

  task automatic test_fixed_priority();
    int gap;
    apply_reset();
    set_req(1, 0, 3'd6, 1'b1, 32'hF0F0_0006);
    set_req(1, 1, 3'd7, 1'b1, 32'hF1F1_0007);
    for (int i = 0; i < 4; i++) serve(1, 0, 2, 32'hC000_0000 + i, (i == 3), gap);
    serve(1, 1, 2, 32'hC100_0000, 1, gap);
    n_tests++;
    if (gap !== 2) begin
      n_fail++;
      $display("FAIL fixed_gap: got %0d required 2", gap);
    end
  endtask

  task automatic test_reset_mid();
    int gap;
    set_req(0, 1, 3'd5, 1'b0, 32'h0);
    tick();
    n_tests++;
    if (tgt_sel_w[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_busy: tgt_sel got %b required 1", tgt_sel_w[0]);
    end
    #2 reset = 1'b1;
    #1 check_zero("async_reset");
    m1_sel[0] = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    tick();
    set_req(0, 1, 3'd5, 1'b0, 32'h0);
    serve(0, 1, 3, 32'hCAFE_0001, 1, gap);
    n_tests++;
    if (gap !== 1) begin
      n_fail++;
      $display("FAIL post_reset_latency: got %0d required 1", gap);
    end
  endtask

`ifdef PPS_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int gap;
    apply_reset();
    set_req(0, 0, 3'd2, 1'b0, 32'h0);
    tick();
    for (int c = 1; c < 16; c++) begin
      tick();
      n_tests++;
      if ({tgt_sel_w[0], m0_ready_w[0], timeout_err_w[0]} !== 3'b100) begin
        n_fail++;
        $display("FAIL to_wait cyc%0d: got %b required 100", c,
                 {tgt_sel_w[0], m0_ready_w[0], timeout_err_w[0]});
      end
    end
    tick();
    n_tests++;
    if ({tgt_sel_w[0], m0_ready_w[0], timeout_err_w[0], m0_rdata_w[0], dbg_state_w[0]} !==
        {3'b011, 32'hDEAD_BEEF, GAP}) begin
      n_fail++;
      $display("FAIL to_expire: got %h required %h",
               {tgt_sel_w[0], m0_ready_w[0], timeout_err_w[0], m0_rdata_w[0], dbg_state_w[0]},
               {3'b011, 32'hDEAD_BEEF, GAP});
    end
    m0_sel[0] = 1'b0;
    tick();
    n_tests++;
    if ({m0_ready_w[0], timeout_err_w[0]} !== 2'b00) begin
      n_fail++;
      $display("FAIL to_pulse_len: got %b required 00", {m0_ready_w[0], timeout_err_w[0]});
    end
    set_req(0, 0, 3'd2, 1'b0, 32'h0);
    serve(0, 0, 16, 32'h1600_0016, 1, gap);
  endtask
`else
  task automatic test_no_timeout();
    int gap;
    apply_reset();
    set_req(0, 0, 3'd2, 1'b0, 32'h0);
    serve(0, 0, 40, 32'h0BAD_F00D, 1, gap);
  endtask
`endif

  initial begin
    clear_inputs();
    test_reset();
    test_single_read();
    test_both_writes();
    test_back_to_back();
    test_idle_ready();
    test_fixed_priority();
    test_reset_mid();
`ifdef PPS_ARB_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
